// File: rtl/timer_pkg.sv
// -----------------------------------------------------------------------------
// timer_pkg
// Shared definitions for the countdown-timer controller: FSM state encoding,
// register offsets on the word-addressed peripheral bus, CTRL bit positions,
// mode codes and the debug view of the controller's internal state.
// -----------------------------------------------------------------------------
package timer_pkg;

  // FSM state encoding (2 bits).
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } timer_state_e;

  // Register offsets.
  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;
  localparam logic [1:0] ADDR_RSVD   = 2'd3;

  // CTRL bit positions.
  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_MODE_MSB = 2;
  localparam int CTRL_IM_BIT   = 3;

  // Mode codes. Codes 2 and 3 are not decoded and behave as one-shot.
  localparam logic [1:0] MODE_ONESHOT = 2'd0;
  localparam logic [1:0] MODE_RELOAD  = 2'd1;

  // Debug view of the controller: FSM state plus the raw (unmasked) flag.
  typedef struct packed {
    timer_state_e state;
    logic         irq_flag;
  } timer_dbg_t;

  // Only the exact auto-reload code reloads; everything else is one-shot.
  function automatic logic is_reload(input logic [1:0] mode);
    return (mode == MODE_RELOAD);
  endfunction

endpackage

// File: rtl/timer_ctrl_if.sv
// -----------------------------------------------------------------------------
// timer_ctrl_if
// Peripheral-bus connection between the CPU (master) and the timer
// controller (slave).
//   addr  : register select (0=CTRL, 1=PRESET, 2=COUNT, 3=reserved)
//   we    : write strobe
//   wdata : write data
//   rdata : combinational read data for addr
//   irq   : interrupt request towards the CPU interrupt logic
//
// Transfer semantics: there is no valid/ready pair on this bus. A write is a
// single-cycle transfer that happens at every rising clk edge where we=1; the
// slave is always ready. A read is a pure combinational lookup of addr and
// never has a side effect.
// -----------------------------------------------------------------------------
interface timer_ctrl_if #(
  parameter int WIDTH = 32
);
  logic [1:0]       addr;
  logic             we;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] rdata;
  logic             irq;

  modport master (
    output addr,
    output we,
    output wdata,
    input  rdata,
    input  irq
  );

  modport slave (
    input  addr,
    input  we,
    input  wdata,
    output rdata,
    output irq
  );
endinterface

// File: rtl/timer_ctrl.sv
// -----------------------------------------------------------------------------
// timer_ctrl
// Bus-programmable controller that sequences the CPU countdown timer.
// Holds CTRL / PRESET / COUNT, runs the IDLE -> LOAD -> CNT -> INT sequence
// and raises an interrupt request. Supports one-shot and auto-reload modes.
//
// Ports
//   clk    : system clock, single domain
//   rst    : synchronous, active-high reset
//   bus    : timer_ctrl_if.slave (addr, we, wdata in; rdata, irq out)
//   o_dbg  : FSM state and raw irq flag, for observation only
// -----------------------------------------------------------------------------
module timer_ctrl
  import timer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst,
  timer_ctrl_if.slave  bus,
  output timer_dbg_t   o_dbg
);

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  logic             r_en;
  logic [1:0]       r_mode;
  logic             r_im;
  logic [WIDTH-1:0] r_preset;
  logic [WIDTH-1:0] r_count;
  logic             r_irq_flag;
  timer_state_e     r_state;

  // ---------------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------------
  logic w_ctrl_wr;
  logic w_preset_wr;
  logic w_force_idle;

  assign w_ctrl_wr   = bus.we && (bus.addr == ADDR_CTRL);
  assign w_preset_wr = bus.we && (bus.addr == ADDR_PRESET);
  // Writing en=0 overrides whatever the FSM would do at this edge.
  assign w_force_idle = w_ctrl_wr && !bus.wdata[CTRL_EN_BIT];

  // ---------------------------------------------------------------------------
  // FSM next-state and datapath controls
  // ---------------------------------------------------------------------------
  timer_state_e w_state_nxt;
  logic         w_load;       // COUNT <= PRESET
  logic         w_dec;        // COUNT <= COUNT - 1
  logic         w_zero;       // COUNT <= 0 on terminal count
  logic         w_flag_set;   // terminal count reached
  logic         w_flag_clr;   // auto-reload drops the flag after one cycle
  logic         w_en_clr;     // one-shot completes and disables itself

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_dec       = 1'b0;
    w_zero      = 1'b0;
    w_flag_set  = 1'b0;
    w_flag_clr  = 1'b0;
    w_en_clr    = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (r_en) w_state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        w_load      = 1'b1;
        w_state_nxt = ST_CNT;
      end
      ST_CNT: begin
        if (!r_en) begin
          w_state_nxt = ST_IDLE;
        end else if (r_count <= WIDTH'(1)) begin
          // COUNT=0 (PRESET=0) is treated like COUNT=1, so it saturates.
          w_zero      = 1'b1;
          w_flag_set  = 1'b1;
          w_state_nxt = ST_INT;
        end else begin
          w_dec = 1'b1;
        end
      end
      ST_INT: begin
        if (is_reload(r_mode)) begin
          w_flag_clr  = 1'b1;
          w_state_nxt = ST_LOAD;
        end else begin
          w_en_clr    = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    // A CTRL write of en=0 freezes COUNT and parks the FSM in IDLE.
    if (w_force_idle) begin
      w_state_nxt = ST_IDLE;
      w_load      = 1'b0;
      w_dec       = 1'b0;
      w_zero      = 1'b0;
      w_flag_set  = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // CTRL and PRESET registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_en     <= 1'b0;
      r_mode   <= MODE_ONESHOT;
      r_im     <= 1'b0;
      r_preset <= '0;
    end else begin
      // A bus write to CTRL wins over the FSM's one-shot en clear.
      if (w_ctrl_wr) begin
        r_en   <= bus.wdata[CTRL_EN_BIT];
        r_mode <= bus.wdata[CTRL_MODE_MSB:CTRL_MODE_LSB];
        r_im   <= bus.wdata[CTRL_IM_BIT];
      end else if (w_en_clr) begin
        r_en <= 1'b0;
      end
      // PRESET only reaches COUNT through LOAD, so a write here never
      // disturbs a count already in progress.
      if (w_preset_wr) begin
        r_preset <= bus.wdata;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // COUNT register (not bus-writable)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (w_load) begin
      r_count <= r_preset;
    end else if (w_zero) begin
      r_count <= '0;
    end else if (w_dec) begin
      r_count <= r_count - WIDTH'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Interrupt flag: set has priority over any clear in the same cycle.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_irq_flag <= 1'b0;
    end else if (w_flag_set) begin
      r_irq_flag <= 1'b1;
    end else if (w_ctrl_wr || w_flag_clr) begin
      r_irq_flag <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Read mux
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] w_ctrl_word;
  logic [WIDTH-1:0] w_rdata;

  always_comb begin
    w_ctrl_word                              = '0;
    w_ctrl_word[CTRL_EN_BIT]                 = r_en;
    w_ctrl_word[CTRL_MODE_MSB:CTRL_MODE_LSB] = r_mode;
    w_ctrl_word[CTRL_IM_BIT]                 = r_im;
  end

  always_comb begin
    w_rdata = '0;
    case (bus.addr)
      ADDR_CTRL:   w_rdata = w_ctrl_word;
      ADDR_PRESET: w_rdata = r_preset;
      ADDR_COUNT:  w_rdata = r_count;
      default:     w_rdata = '0;
    endcase
  end

  assign bus.rdata = w_rdata;
  assign bus.irq   = r_irq_flag & r_im;

  assign o_dbg.state    = r_state;
  assign o_dbg.irq_flag = r_irq_flag;

endmodule

// File: tb/tb_timer_ctrl.sv
// -----------------------------------------------------------------------------
// tb_timer_ctrl
// Self-checking bench for timer_ctrl: a table of register-file vectors
// followed by hand-written multi-cycle sequences for counting, reload,
// disable, masking, reset and simultaneous-event corners.
// -----------------------------------------------------------------------------
module tb_timer_ctrl;
  import timer_pkg::*;

  localparam int WIDTH = 32;
  localparam int W     = WIDTH + 1;   // {irq, rdata}

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  timer_ctrl_if #(.WIDTH(WIDTH)) bus ();
  timer_dbg_t dbg;

  timer_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .o_dbg (dbg)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [W-1:0] exp_q[$];

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [1:0] a, input logic [WIDTH-1:0] d);
    bus.we    = we;
    bus.addr  = a;
    bus.wdata = d;
  endtask

  // One write transfer: captured at the next edge, strobe dropped afterwards.
  task automatic wr(input logic [1:0] a, input logic [WIDTH-1:0] d);
    drive(1'b1, a, d);
    step();
    drive(1'b0, a, '0);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic rd(input string name, input logic [1:0] a, input logic [WIDTH-1:0] exp);
    drive(1'b0, a, '0);
    #1;
    check(name, bus.rdata, exp);
  endtask

  task automatic sb_push(input logic irq, input logic [WIDTH-1:0] d);
    exp_q.push_back({irq, d});
  endtask

  task automatic sb_check(input string name);
    logic [W-1:0] e;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL %s: scoreboard empty, got irq=%0b data=%h", name, bus.irq, bus.rdata);
    end else begin
      e = exp_q.pop_front();
      if ({bus.irq, bus.rdata} !== e) begin
        n_err++;
        $display("FAIL %s: got irq=%0b data=%h expected irq=%0b data=%h",
                 name, bus.irq, bus.rdata, e[W-1], e[WIDTH-1:0]);
      end
    end
  endtask

  // Reference COUNT after edge k of a one-shot run started by a CTRL write at
  // E0 with PRESET=n from IDLE, where prev is COUNT before the run.
  function automatic logic [WIDTH-1:0] model_count(input int k, input int n,
                                                   input logic [WIDTH-1:0] prev);
    int v;
    if (k <= 1) return prev;
    v = n - (k - 2);
    if (v < 0) v = 0;
    return WIDTH'(v);
  endfunction

  // ---------------------------------------------------------------------------
  // Register-file vectors
  // ---------------------------------------------------------------------------
  typedef struct {
    logic             we;
    logic [1:0]       addr;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] exp_rdata;
    logic             exp_irq;
  } vec_t;

  vec_t vecs[12];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_irq;

    vecs[0]  = '{1'b0, ADDR_CTRL,   32'h0,         32'h0,        1'b0};
    vecs[1]  = '{1'b0, ADDR_PRESET, 32'h0,         32'h0,        1'b0};
    vecs[2]  = '{1'b0, ADDR_COUNT,  32'h0,         32'h0,        1'b0};
    vecs[3]  = '{1'b0, ADDR_RSVD,   32'h0,         32'h0,        1'b0};
    vecs[4]  = '{1'b1, ADDR_PRESET, 32'hDEADBEEF,  32'hDEADBEEF, 1'b0};
    vecs[5]  = '{1'b1, ADDR_COUNT,  32'h00001234,  32'h0,        1'b0};
    vecs[6]  = '{1'b1, ADDR_RSVD,   32'h0000FFFF,  32'h0,        1'b0};
    vecs[7]  = '{1'b1, ADDR_CTRL,   32'hFFFFFFF6,  32'h00000006, 1'b0};
    vecs[8]  = '{1'b1, ADDR_CTRL,   32'h00000008,  32'h00000008, 1'b0};
    vecs[9]  = '{1'b1, ADDR_CTRL,   32'h00000000,  32'h0,        1'b0};
    vecs[10] = '{1'b1, ADDR_PRESET, 32'h00000000,  32'h0,        1'b0};
    vecs[11] = '{1'b0, ADDR_PRESET, 32'hFFFFFFFF,  32'h0,        1'b0};

    // Reset
    rst = 1'b1;
    drive(1'b0, ADDR_CTRL, '0);
    repeat (3) step();
    rst = 1'b0;
    #1;
    check("reset_state", WIDTH'(dbg.state), WIDTH'(ST_IDLE));
    check("reset_flag",  WIDTH'(dbg.irq_flag), '0);

    // Register file table
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].we, vecs[i].addr, vecs[i].wdata);
      sb_push(vecs[i].exp_irq, vecs[i].exp_rdata);
      step();
      drive(1'b0, vecs[i].addr, '0);
      #1;
      sb_check($sformatf("regvec%0d", i));
    end
    check("table_idle", WIDTH'(dbg.state), WIDTH'(ST_IDLE));

    // One-shot, PRESET=5, im=1
    wr(ADDR_PRESET, 32'd5);
    wr(ADDR_CTRL, 32'h9);                       // E0
    drive(1'b0, ADDR_COUNT, '0);
    for (int k = 1; k <= 8; k++) begin
      sb_push(k >= 7, model_count(k, 5, '0));
      step();
      sb_check($sformatf("oneshot_e%0d", k));
    end
    rd("oneshot_ctrl_en_cleared", ADDR_CTRL, 32'h8);
    check("oneshot_idle", WIDTH'(dbg.state), WIDTH'(ST_IDLE));
    repeat (3) step();
    check("oneshot_irq_held", WIDTH'(bus.irq), WIDTH'(1));
    wr(ADDR_CTRL, 32'h8);
    check("oneshot_irq_dropped", WIDTH'(bus.irq), '0);

    // Auto-reload, PRESET=3 then 6 written mid-count
    wr(ADDR_PRESET, 32'd3);
    wr(ADDR_CTRL, 32'hB);                       // E0
    n_irq = 0;
    for (int k = 1; k <= 32; k++) begin
      if (k == 13) drive(1'b1, ADDR_PRESET, 32'd6);
      else         drive(1'b0, ADDR_COUNT, '0);
      step();
      check($sformatf("reload_irq_e%0d", k), WIDTH'(bus.irq),
            WIDTH'(k == 5 || k == 10 || k == 15 || k == 23 || k == 31));
    end
    wr(ADDR_CTRL, 32'h0);
    check("reload_stop_idle", WIDTH'(dbg.state), WIDTH'(ST_IDLE));
    check("reload_stop_irq",  WIDTH'(bus.irq), '0);

    // Mid-count disable at COUNT=4, then re-enable
    wr(ADDR_PRESET, 32'd8);
    wr(ADDR_CTRL, 32'h1);                       // E0
    drive(1'b0, ADDR_COUNT, '0);
    repeat (6) step();
    check("dis_count_before", bus.rdata, 32'd4);
    wr(ADDR_CTRL, 32'h0);
    rd("dis_count_frozen", ADDR_COUNT, 32'd4);
    check("dis_idle", WIDTH'(dbg.state), WIDTH'(ST_IDLE));
    check("dis_irq",  WIDTH'(bus.irq), '0);
    repeat (3) step();
    check("dis_count_still", bus.rdata, 32'd4);
    wr(ADDR_CTRL, 32'h1);                       // F0
    drive(1'b0, ADDR_COUNT, '0);
    step();
    step();
    check("reen_reload", bus.rdata, 32'd8);
    check("reen_cnt", WIDTH'(dbg.state), WIDTH'(ST_CNT));
    wr(ADDR_CTRL, 32'h0);

    // Masked one-shot, PRESET=2
    wr(ADDR_PRESET, 32'd2);
    wr(ADDR_CTRL, 32'h1);                       // E0
    repeat (4) step();
    check("mask_int_state", WIDTH'(dbg.state), WIDTH'(ST_INT));
    check("mask_flag_set", WIDTH'(dbg.irq_flag), WIDTH'(1));
    check("mask_irq_low",  WIDTH'(bus.irq), '0);
    step();
    check("mask_flag_held", WIDTH'(dbg.irq_flag), WIDTH'(1));
    check("mask_irq_low2",  WIDTH'(bus.irq), '0);
    wr(ADDR_CTRL, 32'h8);
    check("mask_flag_cleared", WIDTH'(dbg.irq_flag), '0);
    check("mask_irq_after_im", WIDTH'(bus.irq), '0);

    // Reset mid-count at COUNT=10
    wr(ADDR_PRESET, 32'd20);
    wr(ADDR_CTRL, 32'h9);                       // E0
    drive(1'b0, ADDR_COUNT, '0);
    repeat (12) step();
    check("rst_count_before", bus.rdata, 32'd10);
    check("rst_cnt_state", WIDTH'(dbg.state), WIDTH'(ST_CNT));
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check("rst_count", bus.rdata, '0);
    rd("rst_ctrl",   ADDR_CTRL,   '0);
    rd("rst_preset", ADDR_PRESET, '0);
    check("rst_irq",   WIDTH'(bus.irq), '0);
    check("rst_state", WIDTH'(dbg.state), WIDTH'(ST_IDLE));

    // PRESET=0 boundary plus simultaneous CTRL-write corners
    wr(ADDR_CTRL, 32'h9);                       // E0, PRESET is 0
    drive(1'b0, ADDR_COUNT, '0);
    step();
    step();
    check("p0_irq_e2", WIDTH'(bus.irq), '0);
    step();
    check("p0_irq_e3", WIDTH'(bus.irq), WIDTH'(1));
    check("p0_int_e3", WIDTH'(dbg.state), WIDTH'(ST_INT));
    wr(ADDR_CTRL, 32'h9);                       // E4: written en wins over clear
    rd("int_wr_ctrl", ADDR_CTRL, 32'h9);
    check("int_wr_idle", WIDTH'(dbg.state), WIDTH'(ST_IDLE));
    check("int_wr_irq",  WIDTH'(bus.irq), '0);
    step();                                     // E5 LOAD
    step();                                     // E6 CNT
    drive(1'b1, ADDR_CTRL, 32'h9);              // E7: flag set vs CTRL clear
    step();
    drive(1'b0, ADDR_CTRL, '0);
    check("setprio_irq",   WIDTH'(bus.irq), WIDTH'(1));
    check("setprio_state", WIDTH'(dbg.state), WIDTH'(ST_INT));
    wr(ADDR_CTRL, 32'h0);

    // Final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/timer_ctrl.md
Name: timer_ctrl

Overview:
- Bus-programmable controller that sequences the CPU's countdown timer.
- Holds CTRL / PRESET / COUNT registers on the CPU's word-addressed peripheral bus.
- Runs a load/count/interrupt FSM and raises an interrupt request to the CPU interrupt logic.
- Supports one-shot and auto-reload modes.

Parameters:
- WIDTH, 32, width of PRESET, COUNT and the data bus.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- addr  in  2  register select: 0=CTRL, 1=PRESET, 2=COUNT, 3=reserved.
- we  in  1  write strobe, sampled on the rising edge of clk.
- wdata  in  WIDTH  write data.
- rdata  out  WIDTH  combinational read data for addr.
- irq  out  1  interrupt request, equal to irq_flag AND CTRL.im.

Behaviour:
- Reset: CTRL=0, PRESET=0, COUNT=0, irq_flag=0, state=IDLE, irq=0.
- CTRL bit fields; all other bits read as 0:
  - bit0 en: enable.
  - bits2:1 mode: 0=one-shot, 1=auto-reload, 2/3 behave as 0.
  - bit3 im: interrupt mask, 1=enabled.
- Reads:
  - addr 0 returns CTRL; addr 1 returns PRESET; addr 2 returns COUNT; addr 3 returns 0.
  - Reads have no side effects.
- Writes:
  - CTRL and PRESET are writable.
  - Writes to COUNT and reserved are ignored.
  - Any CTRL write clears irq_flag.
  - A PRESET write takes effect at the next LOAD only.
- FSM, one transition per clock:
  - IDLE: if en, go to LOAD.
  - LOAD: COUNT <= PRESET; go to CNT.
  - CNT:
    - if en=0, go to IDLE and COUNT holds its value;
    - else if COUNT <= 1, COUNT <= 0, irq_flag <= 1, go to INT;
    - else COUNT <= COUNT-1.
  - INT:
    - mode 1: irq_flag <= 0 and go to LOAD; irq is a one-cycle pulse.
    - mode 0: en <= 0 and go to IDLE; irq_flag stays set until the next CTRL write.
- Latency: with CTRL write (en=1) captured at edge E0 and PRESET=N≥1:
  - LOAD at E1, COUNT=N after E2;
  - COUNT=1 after E(N+1);
  - INT and irq high after E(N+2).
  - PRESET=0 behaves like PRESET=1: INT after E3.
- Auto-reload period is N+2 cycles, counted INT to INT.
- Simultaneous events:
  - A CTRL write in the same cycle as the FSM's en-clear in INT: the written value wins.
  - A CTRL write in the same cycle irq_flag would set: the flag still sets, because the set has priority over the clear.
  - Writing en=0 in any state forces IDLE at that edge; COUNT is frozen, not cleared.
  - Re-enabling from IDLE always reloads from PRESET.
- rst asserted mid-count returns every register and the FSM to reset values at that edge.
- Arithmetic: unsigned WIDTH bits; no wrap, because COUNT saturates at 0.

Decomposition:
- Shared package timer_pkg holds:
  - FSM state encoding: IDLE, LOAD, CNT, INT, 2 bits;
  - register offsets;
  - CTRL bit positions;
  - mode codes.
- No sub-module: one flat block with a register file, the FSM and the counter.

Test Plan:
- Reset then read all addresses -> rdata=0 for each; irq=0.
- PRESET=5, CTRL=0b1001 (en, mode 0, im) -> COUNT reads 5,4,3,2,1,0 on successive cycles; irq rises 7 cycles after the CTRL write edge and stays high; CTRL.en reads 0; a CTRL write drops irq.
- PRESET=3, CTRL=0b1011 (auto-reload) -> irq one-cycle pulses every 5 cycles; a PRESET=6 write mid-count changes the period to 8 from the next reload.
- Mid-count CTRL write en=0 with COUNT=4 -> COUNT holds 4, FSM in IDLE, no irq; re-enable reloads PRESET.
- im=0, mode 0, PRESET=2 -> irq stays 0 while irq_flag is set; writing im=1 in that CTRL write clears the flag, so irq stays 0.
- rst pulse while COUNT=10 in CNT -> next cycle COUNT=0, CTRL=0, irq=0, FSM in IDLE.
